regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with per-entry busy bits and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ready_q, ready_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = RUN;
          ready_d = 1'b1;
          ptr_d   = '0;
        end
      end
      RUN: ;
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Port 1 is applied after port 0 so it wins on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[ptr_q] = '0;
    end else if (ready_q) begin
      if (we0 && waddr0 != '0) mem_d[waddr0] = wdata0;
      if (we1 && waddr1 != '0) mem_d[waddr1] = wdata1;
    end
  end

  // Storage is not reset; the clear sweep zeroes it after every reset release.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Set is applied after the write-port clears so it wins on the same entry.
  always_comb begin
    busy_d = busy_q;
    if (ready_q) begin
      if (we0) busy_d[waddr0] = 1'b0;
      if (we1) busy_d[waddr1] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rdata1 = '0;
    if (ready_q && raddr1 != '0) begin
      rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (we0 && waddr0 == raddr1) rdata1 = wdata0;
      if (we1 && waddr1 == raddr1) rdata1 = wdata1;
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (ready_q && raddr2 != '0) begin
      rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (we0 && waddr0 == raddr2) rdata2 = wdata0;
      if (we1 && waddr1 == raddr2) rdata2 = wdata1;
`endif
    end
  end

  assign busy1 = ready_q && (raddr1 != '0) && busy_q[raddr1];
  assign busy2 = ready_q && (raddr2 != '0) && busy_q[raddr2];
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0, set_en = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0, raddr1 = '0, raddr2 = '0, set_addr = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2, ready;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .set_en(set_en), .set_addr(set_addr),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; set_en = 1'b0;
  endtask

  // Releases reset on a falling edge and checks ready over the following 32 rising edges.
  task automatic sweep_check(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (ready !== (i == 32)) begin
        miscompares++;
        $display("FAIL %s ready at edge %0d: got %b want %b", name, i, ready, (i == 32));
      end
    end
  endtask

  task automatic test_reset();
    idle();
    raddr1 = 5'd4; raddr2 = 5'd1;
    #12;
    vectors++;
    if ({ready, busy1, busy2, rdata1, rdata2} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b busy=%b%b rd=%h/%h want all 0",
               ready, busy1, busy2, rdata1, rdata2);
    end
    // Writes and sets during the sweep must be discarded.
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hFFFF_FFFF;
    set_en = 1'b1; set_addr = 5'd4;
    sweep_check("initial_sweep");
    idle();
    #1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      vectors++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL cleared_read addr %0d: got %h/%h busy=%b want 0/0/0", a, rdata1, rdata2, busy1);
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF; raddr1 = 5'd3;
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_addr3: got %h want deadbeef", rdata1);
    end
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h1234_5678; raddr2 = 5'd12;
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (rdata2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_port1_addr12: got %h want 12345678", rdata2);
    end
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hCAFE_F00D;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hBAAD_F00D;
    @(negedge clk);
    idle();
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL write_addr0: got %h/%h want 0/0", rdata1, rdata2);
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    @(negedge clk);
    idle();
    raddr1 = 5'd7;
    #1;
    vectors++;
    if (rdata1 !== 32'h22) begin
      miscompares++;
      $display("FAIL collide_addr7: got %h want 00000022", rdata1);
    end
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'hA0A0_0008;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hB0B0_0006;
    @(negedge clk);
    idle();
    raddr1 = 5'd8; raddr2 = 5'd6;
    #1;
    vectors++;
    if (rdata1 !== 32'hA0A0_0008 || rdata2 !== 32'hB0B0_0006) begin
      miscompares++;
      $display("FAIL dual_write_8_6: got %h/%h want a0a00008/b0b00006", rdata1, rdata2);
    end
  endtask

  task automatic test_busy();
    @(negedge clk);
    raddr1 = 5'd5; raddr2 = 5'd6;
    set_en = 1'b1; set_addr = 5'd5;
    #1;
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_before_edge: got %b want 0", busy1);
    end
    @(negedge clk);
    set_addr = 5'd6;
    #1;
    vectors++;
    if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_set5: got %b%b want 10", busy1, busy2);
    end
    @(negedge clk);
    idle();
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h5;
    #1;
    vectors++;
    if (busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_set6: got %b want 1", busy2);
    end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy1 !== 1'b0 || busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_clear5: got %b%b want 01", busy1, busy2);
    end
    set_en = 1'b1; set_addr = 5'd5;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h55;
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_set_wins: got %b want 1", busy1);
    end
    set_en = 1'b1; set_addr = 5'd0;
    @(negedge clk);
    idle();
    raddr2 = 5'd0;
    #1;
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_addr0: got %b want 0", busy2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAA;
    @(negedge clk);
    wdata0 = 32'h55; raddr2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'hAA;
`endif
    #1;
    vectors++;
    if (rdata2 !== exp_same) begin
      miscompares++;
      $display("FAIL same_cycle_read9: got %h want %h", rdata2, exp_same);
    end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (rdata2 !== 32'h55) begin
      miscompares++;
      $display("FAIL after_write9: got %h want 00000055", rdata2);
    end
  endtask

  task automatic test_reset_run();
    @(negedge clk);
    raddr1 = 5'd5; raddr2 = 5'd7;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready, busy1, busy2, rdata1, rdata2} !== '0) begin
      miscompares++;
      $display("FAIL run_reset_outputs: got ready=%b busy=%b%b rd=%h/%h want all 0",
               ready, busy1, busy2, rdata1, rdata2);
    end
    sweep_check("run_reset_sweep");
    #1;
    vectors++;
    if (busy1 !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL run_reset_state: got busy=%b rd=%h/%h want 0/0/0", busy1, rdata1, rdata2);
    end
  endtask

  task automatic test_reset_sweep();
    @(negedge clk);
    we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h2020_2020;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    raddr1 = 5'd20;
    #1;
    vectors++;
    if (ready !== 1'b0 || rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL sweep_reset_outputs: got ready=%b rd=%h want 0/0", ready, rdata1);
    end
    sweep_check("restart_sweep");
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL restart_cleared20: got %h want 0", rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_same_addr();
    test_busy();
    test_bypass();
    test_reset_run();
    test_reset_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
